cve2_mac_sequencer: RTL and testbench

// - Sequences multi-cycle multiply-accumulate ops over the shared ALU in the EX stage.
// - Sits between the ID decoder and the ALU.
// - Replaces the fixed 2-cycle MAC path. Adds: configurable multiply latency,

---
 rtl/cve2_pkg.sv | 38 +++
 rtl/cve2_mac_acc_rf.sv | 64 ++++++
 rtl/cve2_mac_sequencer.sv | 158 +++++++++++++++
 tb/tb_cve2_mac_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cve2_pkg.sv
// Shared CVE2 types used by the EX-stage MAC sequencer: ALU operators, MAC modes
// and sizing helpers.
package cve2_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_XOR = 4'd2,
        ALU_OR  = 4'd3,
        ALU_AND = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SLT = 4'd8,
        ALU_MUL = 4'd9,
        ALU_MAC = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        MAC_ACC = 2'd0,
        MAC_SUB = 2'd1,
        MAC_CLR = 2'd2
    } mac_mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StAcc
    } mac_state_e;

    localparam int unsigned MacMaxMulCycles = 4;
    localparam int unsigned MacCntW         = $clog2(MacMaxMulCycles);

    function automatic int unsigned acc_idx_width(int unsigned num_acc);
        return (num_acc > 1) ? $clog2(num_acc) : 1;
    endfunction

endpackage

// File: rtl/cve2_mac_acc_rf.sv
// Accumulator register file for the MAC sequencer: one write port with optional
// signed saturation, one read at the latched index and one combinational read.
module cve2_mac_acc_rf import cve2_pkg::*; #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumAcc    = 1,
    parameter bit          SatEn     = 1'b0,
    localparam int unsigned AccIdxW  = acc_idx_width(NumAcc)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [AccIdxW-1:0]   waddr_i,
    input  logic                 sat_chk_i,
    input  logic                 sub_i,
    input  logic [DataWidth-1:0] opnd_a_i,
    input  logic [DataWidth-1:0] opnd_b_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic [DataWidth-1:0] wacc_o,
    input  logic [AccIdxW-1:0]   raddr_i,
    output logic [DataWidth-1:0] racc_o
);

    logic [DataWidth-1:0] acc_q [NumAcc];
    logic [AccIdxW-1:0]   widx, ridx;
    logic                 sign_a, sign_b, sign_r, ovf;
    logic [DataWidth-1:0] sat_val, wdata_sat;

    function automatic logic [AccIdxW-1:0] wrap_idx(logic [AccIdxW-1:0] idx);
        return AccIdxW'(32'(idx) % NumAcc);
    endfunction

    assign widx = wrap_idx(waddr_i);
    assign ridx = wrap_idx(raddr_i);

    // ADD overflows when like-signed operands give an unlike result; SUB when
    // the operands differ in sign and the result flips away from A.
    assign sign_a    = opnd_a_i[DataWidth-1];
    assign sign_b    = opnd_b_i[DataWidth-1];
    assign sign_r    = wdata_i[DataWidth-1];
    assign ovf       = sat_chk_i & (sub_i ? (sign_a != sign_b) : (sign_a == sign_b))
                     & (sign_r != sign_a);
    assign sat_val   = sign_a ? {1'b1, {(DataWidth-1){1'b0}}} : {1'b0, {(DataWidth-1){1'b1}}};
    assign wdata_sat = (SatEn && ovf) ? sat_val : wdata_i;

    always_comb begin
        wacc_o = '0;
        racc_o = '0;
        for (int unsigned i = 0; i < NumAcc; i++) begin
            if (widx == AccIdxW'(i)) wacc_o = acc_q[i];
            if (ridx == AccIdxW'(i)) racc_o = acc_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumAcc; i++) acc_q[i] <= '0;
        end else if (we_i) begin
            for (int unsigned i = 0; i < NumAcc; i++) begin
                if (widx == AccIdxW'(i)) acc_q[i] <= wdata_sat;
            end
        end
    end

endmodule

// File: rtl/cve2_mac_sequencer.sv
// EX-stage MAC sequencer: runs ALU_MAC as a multi-cycle ALU_MUL followed by an
// ALU_ADD/ALU_SUB into one of NumAcc internal accumulators.
module cve2_mac_sequencer import cve2_pkg::*; #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MulCycles = 1,
    parameter int unsigned NumAcc    = 1,
    parameter bit          SatEn     = 1'b0,
    localparam int unsigned AccIdxW  = acc_idx_width(NumAcc)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  alu_op_e              alu_operator_i,
    input  mac_mode_e            mode_i,
    input  logic [AccIdxW-1:0]   acc_sel_i,
    input  logic                 flush_i,
    input  logic [DataWidth-1:0] result_i,
    output alu_op_e              alu_operator_o,
    output logic                 opnd_ovr_o,
    output logic [DataWidth-1:0] opnd_a_o,
    output logic [DataWidth-1:0] opnd_b_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DataWidth-1:0] acc_o
);

    if (MulCycles < 1 || MulCycles > MacMaxMulCycles) begin : gen_bad_mul_cycles
        $error("MulCycles must be in 1..%0d", MacMaxMulCycles);
    end
    if (NumAcc < 1 || NumAcc > 4) begin : gen_bad_num_acc
        $error("NumAcc must be in 1..4");
    end

    mac_state_e           state_q, state_d;
    logic [MacCntW-1:0]   cnt_q, cnt_d;
    mac_mode_e            mode_q, mode_d;
    logic [AccIdxW-1:0]   sel_q, sel_d;
    logic [DataWidth-1:0] prod_q, prod_d;

    logic                 accept;
    logic                 acc_we;
    logic                 sat_chk;
    logic [DataWidth-1:0] acc_cur;

    assign accept = req_i && (alu_operator_i == ALU_MAC) && !flush_i;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mode_d         = mode_q;
        sel_d          = sel_q;
        prod_d         = prod_q;
        alu_operator_o = alu_operator_i;
        opnd_ovr_o     = 1'b0;
        opnd_a_o       = '0;
        opnd_b_o       = '0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        acc_we         = 1'b0;
        sat_chk        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // The accept cycle already counts as the first multiply cycle.
                if (accept) begin
                    alu_operator_o = ALU_MUL;
                    busy_o         = 1'b1;
                    mode_d         = mode_i;
                    sel_d          = acc_sel_i;
                    if (MulCycles == 1) begin
                        prod_d  = result_i;
                        state_d = StAcc;
                    end else begin
                        cnt_d   = MacCntW'(MulCycles - 2);
                        state_d = StMul;
                    end
                end
            end
            StMul: begin
                alu_operator_o = ALU_MUL;
                busy_o         = 1'b1;
                if (flush_i) begin
                    state_d = StIdle;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    prod_d  = result_i;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                opnd_ovr_o = 1'b1;
                state_d    = StIdle;
                case (mode_q)
                    MAC_SUB: begin
                        alu_operator_o = ALU_SUB;
                        opnd_a_o       = acc_cur;
                        opnd_b_o       = prod_q;
                        sat_chk        = 1'b1;
                    end
                    MAC_CLR: begin
                        alu_operator_o = ALU_ADD;
                        opnd_a_o       = prod_q;
                    end
                    default: begin
                        alu_operator_o = ALU_ADD;
                        opnd_a_o       = prod_q;
                        opnd_b_o       = acc_cur;
                        sat_chk        = 1'b1;
                    end
                endcase
                done_o = !flush_i;
                acc_we = !flush_i;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= MAC_ACC;
            sel_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            prod_q  <= prod_d;
        end
    end

    cve2_mac_acc_rf #(
        .DataWidth (DataWidth),
        .NumAcc    (NumAcc),
        .SatEn     (SatEn)
    ) u_acc_rf (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .we_i      (acc_we),
        .waddr_i   (sel_q),
        .sat_chk_i (sat_chk),
        .sub_i     (mode_q == MAC_SUB),
        .opnd_a_i  (opnd_a_o),
        .opnd_b_i  (opnd_b_o),
        .wdata_i   (result_i),
        .wacc_o    (acc_cur),
        .raddr_i   (acc_sel_i),
        .racc_o    (acc_o)
    );

    // ID must hold off further MACs until the sequencer is back in idle.
    mac_req_while_active: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(req_i && (alu_operator_i == ALU_MAC) && (state_q != StIdle)));

endmodule

// File: tb/tb_cve2_mac_sequencer.sv
// Directed bench for cve2_mac_sequencer: four parameterisations share one stimulus
// stream, each with its own behavioural ALU closing the result loop.
module tb_cve2_mac_sequencer;
    import cve2_pkg::*;

    logic        clk, rst_n, req, flush;
    alu_op_e     op_in;
    mac_mode_e   mode;
    logic [1:0]  sel;
    logic [31:0] rs1, rs2;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_op_e     aop_m1, aop_m3, aop_n4, aop_st;
    logic        ovr_m1, ovr_m3, ovr_n4, ovr_st;
    logic        busy_m1, busy_m3, busy_n4, busy_st;
    logic        done_m1, done_m3, done_n4, done_st;
    logic [31:0] oa_m1, oa_m3, oa_n4, oa_st, ob_m1, ob_m3, ob_n4, ob_st;
    logic [31:0] acc_m1, acc_m3, acc_n4, acc_st, res_m1, res_m3, res_n4, res_st;

    function automatic logic [31:0] alu(alu_op_e op, logic [31:0] a, logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_MUL: return a * b;
            ALU_XOR: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    assign res_m1 = alu(aop_m1, ovr_m1 ? oa_m1 : rs1, ovr_m1 ? ob_m1 : rs2);
    assign res_m3 = alu(aop_m3, ovr_m3 ? oa_m3 : rs1, ovr_m3 ? ob_m3 : rs2);
    assign res_n4 = alu(aop_n4, ovr_n4 ? oa_n4 : rs1, ovr_n4 ? ob_n4 : rs2);
    assign res_st = alu(aop_st, ovr_st ? oa_st : rs1, ovr_st ? ob_st : rs2);

    cve2_mac_sequencer #(.DataWidth(32), .MulCycles(1), .NumAcc(1), .SatEn(1'b0)) u_m1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .alu_operator_i(op_in), .mode_i(mode),
        .acc_sel_i(sel[0:0]), .flush_i(flush), .result_i(res_m1), .alu_operator_o(aop_m1),
        .opnd_ovr_o(ovr_m1), .opnd_a_o(oa_m1), .opnd_b_o(ob_m1), .busy_o(busy_m1),
        .done_o(done_m1), .acc_o(acc_m1)
    );
    cve2_mac_sequencer #(.DataWidth(32), .MulCycles(3), .NumAcc(1), .SatEn(1'b0)) u_m3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .alu_operator_i(op_in), .mode_i(mode),
        .acc_sel_i(sel[0:0]), .flush_i(flush), .result_i(res_m3), .alu_operator_o(aop_m3),
        .opnd_ovr_o(ovr_m3), .opnd_a_o(oa_m3), .opnd_b_o(ob_m3), .busy_o(busy_m3),
        .done_o(done_m3), .acc_o(acc_m3)
    );
    cve2_mac_sequencer #(.DataWidth(32), .MulCycles(1), .NumAcc(4), .SatEn(1'b0)) u_n4 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .alu_operator_i(op_in), .mode_i(mode),
        .acc_sel_i(sel), .flush_i(flush), .result_i(res_n4), .alu_operator_o(aop_n4),
        .opnd_ovr_o(ovr_n4), .opnd_a_o(oa_n4), .opnd_b_o(ob_n4), .busy_o(busy_n4),
        .done_o(done_n4), .acc_o(acc_n4)
    );
    cve2_mac_sequencer #(.DataWidth(32), .MulCycles(1), .NumAcc(1), .SatEn(1'b1)) u_st (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .alu_operator_i(op_in), .mode_i(mode),
        .acc_sel_i(sel[0:0]), .flush_i(flush), .result_i(res_st), .alu_operator_o(aop_st),
        .opnd_ovr_o(ovr_st), .opnd_a_o(oa_st), .opnd_b_o(ob_st), .busy_o(busy_st),
        .done_o(done_st), .acc_o(acc_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 1'b0; flush = 1'b0; op_in = ALU_XOR; mode = MAC_ACC; sel = 2'd0;
        rs1 = 32'd0; rs2 = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) next_cycle();
        rst_n = 1'b1;
    endtask

    // One MAC issue, then enough idle cycles for the MulCycles=3 instance to finish.
    task automatic mac_run(input mac_mode_e m, input logic [1:0] s,
                           input logic [31:0] a, input logic [31:0] b);
        req = 1'b1; op_in = ALU_MAC; mode = m; sel = s; rs1 = a; rs2 = b;
        next_cycle();
        req = 1'b0;
        repeat (4) next_cycle();
        op_in = ALU_XOR;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        tests_run++; if (busy_m1 !== 1'b0) begin tests_failed++;
            $display("FAIL reset_busy: got %b want 0", busy_m1); end
        tests_run++; if (done_m1 !== 1'b0) begin tests_failed++;
            $display("FAIL reset_done: got %b want 0", done_m1); end
        tests_run++; if (ovr_m1 !== 1'b0) begin tests_failed++;
            $display("FAIL reset_ovr: got %b want 0", ovr_m1); end
        tests_run++; if (oa_m1 !== 32'd0 || ob_m1 !== 32'd0) begin tests_failed++;
            $display("FAIL reset_opnd: got a=%h b=%h want 0", oa_m1, ob_m1); end
        tests_run++; if (acc_m1 !== 32'd0) begin tests_failed++;
            $display("FAIL reset_acc: got %h want 0", acc_m1); end
        tests_run++; if (aop_m1 !== ALU_XOR) begin tests_failed++;
            $display("FAIL reset_pass_xor: got %0d want %0d", aop_m1, ALU_XOR); end
        op_in = ALU_SUB;
        #1;
        tests_run++; if (aop_m1 !== ALU_SUB) begin tests_failed++;
            $display("FAIL reset_pass_sub: got %0d want %0d", aop_m1, ALU_SUB); end
        repeat (2) next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        req = 1'b1; op_in = ALU_MAC; mode = MAC_ACC; sel = 2'd0; rs1 = 32'd3; rs2 = 32'd4;
        @(negedge clk);
        tests_run++; if (aop_m1 !== ALU_MUL || busy_m1 !== 1'b1 || ovr_m1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_c0: got op=%0d busy=%b ovr=%b want op=%0d busy=1 ovr=0",
                     aop_m1, busy_m1, ovr_m1, ALU_MUL); end
        tests_run++; if (done_m1 !== 1'b0) begin tests_failed++;
            $display("FAIL basic_c0_done: got %b want 0", done_m1); end
        next_cycle();
        req = 1'b0;
        @(negedge clk);
        tests_run++; if (aop_m1 !== ALU_ADD || oa_m1 !== 32'd12 || ob_m1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL basic_c1_ops: got op=%0d a=%0d b=%0d want op=%0d a=12 b=0",
                     aop_m1, oa_m1, ob_m1, ALU_ADD); end
        tests_run++; if (done_m1 !== 1'b1 || busy_m1 !== 1'b0 || ovr_m1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_c1_ctl: got done=%b busy=%b ovr=%b want 1 0 1",
                     done_m1, busy_m1, ovr_m1); end
        tests_run++; if (acc_m1 !== 32'd0) begin tests_failed++;
            $display("FAIL basic_c1_old_acc: got %0d want 0", acc_m1); end
        next_cycle();
        op_in = ALU_XOR;
        @(negedge clk);
        tests_run++; if (acc_m1 !== 32'd12) begin tests_failed++;
            $display("FAIL basic_acc: got %0d want 12", acc_m1); end
        tests_run++; if (done_m1 !== 1'b0 || aop_m1 !== ALU_XOR) begin tests_failed++;
            $display("FAIL basic_c2: got done=%b op=%0d want 0 %0d", done_m1, aop_m1, ALU_XOR); end
        repeat (3) next_cycle();
    endtask

    task automatic test_latency();
        do_reset();
        mac_run(MAC_CLR, 2'd0, 32'd2, 32'd5);
        req = 1'b1; op_in = ALU_MAC; mode = MAC_ACC; rs1 = 32'd5; rs2 = 32'd6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (aop_m3 !== ALU_MUL || busy_m3 !== 1'b1 || done_m3 !== 1'b0) begin
                tests_failed++;
                $display("FAIL lat_mul_c%0d: got op=%0d busy=%b done=%b want %0d 1 0",
                         i, aop_m3, busy_m3, done_m3, ALU_MUL); end
            next_cycle();
            req = 1'b0;
        end
        @(negedge clk);
        tests_run++; if (aop_m3 !== ALU_ADD || oa_m3 !== 32'd30 || ob_m3 !== 32'd10) begin
            tests_failed++;
            $display("FAIL lat_c3_ops: got op=%0d a=%0d b=%0d want %0d 30 10",
                     aop_m3, oa_m3, ob_m3, ALU_ADD); end
        tests_run++; if (done_m3 !== 1'b1 || busy_m3 !== 1'b0) begin tests_failed++;
            $display("FAIL lat_c3_ctl: got done=%b busy=%b want 1 0", done_m3, busy_m3); end
        next_cycle();
        op_in = ALU_XOR;
        @(negedge clk);
        tests_run++; if (aop_m3 !== ALU_XOR || busy_m3 !== 1'b0 || done_m3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat_c4_pass: got op=%0d busy=%b done=%b want %0d 0 0",
                     aop_m3, busy_m3, done_m3, ALU_XOR); end
        tests_run++; if (acc_m3 !== 32'd40) begin tests_failed++;
            $display("FAIL lat_acc: got %0d want 40", acc_m3); end
        next_cycle();
    endtask

    task automatic test_multi_acc();
        do_reset();
        mac_run(MAC_ACC, 2'd2, 32'd7, 32'd7);
        req = 1'b1; op_in = ALU_MAC; mode = MAC_SUB; sel = 2'd2; rs1 = 32'd2; rs2 = 32'd3;
        next_cycle();
        req = 1'b0;
        @(negedge clk);
        tests_run++; if (aop_n4 !== ALU_SUB || oa_n4 !== 32'd49 || ob_n4 !== 32'd6) begin
            tests_failed++;
            $display("FAIL macc_sub_ops: got op=%0d a=%0d b=%0d want %0d 49 6",
                     aop_n4, oa_n4, ob_n4, ALU_SUB); end
        repeat (4) next_cycle();
        op_in = ALU_XOR;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            tests_run++; if (acc_n4 !== ((s == 2) ? 32'd43 : 32'd0)) begin tests_failed++;
                $display("FAIL macc_acc%0d: got %0d want %0d", s, acc_n4,
                         (s == 2) ? 43 : 0); end
        end
        sel = 2'd3;
        #1;
        tests_run++; if (acc_m1 !== 32'd43) begin tests_failed++;
            $display("FAIL macc_single_sel_ignored: got %0d want 43", acc_m1); end
        sel = 2'd0;
    endtask

    task automatic test_saturation();
        do_reset();
        mac_run(MAC_CLR, 2'd0, 32'h7FFF_FFF0, 32'd1);
        mac_run(MAC_ACC, 2'd0, 32'd4, 32'd8);
        tests_run++; if (acc_st !== 32'h7FFF_FFFF) begin tests_failed++;
            $display("FAIL sat_pos: got %h want 7fffffff", acc_st); end
        tests_run++; if (acc_m1 !== 32'h8000_0010) begin tests_failed++;
            $display("FAIL wrap_pos: got %h want 80000010", acc_m1); end
        do_reset();
        mac_run(MAC_CLR, 2'd0, 32'h8000_0005, 32'd1);
        mac_run(MAC_SUB, 2'd0, 32'd2, 32'd3);
        tests_run++; if (acc_st !== 32'h8000_0000) begin tests_failed++;
            $display("FAIL sat_neg: got %h want 80000000", acc_st); end
        tests_run++; if (acc_m1 !== 32'h7FFF_FFFF) begin tests_failed++;
            $display("FAIL wrap_neg: got %h want 7fffffff", acc_m1); end
    endtask

    task automatic test_flush();
        do_reset();
        mac_run(MAC_ACC, 2'd0, 32'd2, 32'd5);
        req = 1'b1; op_in = ALU_MAC; mode = MAC_ACC; rs1 = 32'd5; rs2 = 32'd6;
        next_cycle();
        req = 1'b0; flush = 1'b1;
        @(negedge clk);
        tests_run++; if (busy_m3 !== 1'b1) begin tests_failed++;
            $display("FAIL flush_mul_busy: got %b want 1", busy_m3); end
        tests_run++; if (done_m1 !== 1'b0) begin tests_failed++;
            $display("FAIL flush_acc_done: got %b want 0", done_m1); end
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        tests_run++; if (busy_m3 !== 1'b0 || done_m3 !== 1'b0 || aop_m3 !== ALU_MAC) begin
            tests_failed++;
            $display("FAIL flush_idle: got busy=%b done=%b op=%0d want 0 0 %0d",
                     busy_m3, done_m3, aop_m3, ALU_MAC); end
        next_cycle();
        @(negedge clk);
        tests_run++; if (done_m3 !== 1'b0 || acc_m3 !== 32'd10 || acc_m1 !== 32'd10) begin
            tests_failed++;
            $display("FAIL flush_acc_kept: got done=%b m3=%0d m1=%0d want 0 10 10",
                     done_m3, acc_m3, acc_m1); end
        next_cycle();
        req = 1'b1; flush = 1'b1;
        @(negedge clk);
        tests_run++; if (busy_m1 !== 1'b0 || aop_m1 !== ALU_MAC) begin tests_failed++;
            $display("FAIL flush_block_accept: got busy=%b op=%0d want 0 %0d",
                     busy_m1, aop_m1, ALU_MAC); end
        next_cycle();
        req = 1'b0; flush = 1'b0;
        @(negedge clk);
        tests_run++; if (busy_m1 !== 1'b0 || done_m1 !== 1'b0) begin tests_failed++;
            $display("FAIL flush_block_next: got busy=%b done=%b want 0 0", busy_m1, done_m1); end
        next_cycle();
        mac_run(MAC_ACC, 2'd0, 32'd5, 32'd6);
        tests_run++; if (acc_m3 !== 32'd40 || acc_m1 !== 32'd40) begin tests_failed++;
            $display("FAIL flush_resume: got m3=%0d m1=%0d want 40 40", acc_m3, acc_m1); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mac_run(MAC_CLR, 2'd0, 32'd1, 32'd9);
        req = 1'b1; op_in = ALU_MAC; mode = MAC_ACC; rs1 = 32'd3; rs2 = 32'd4;
        next_cycle();
        req = 1'b0;
        @(negedge clk);
        tests_run++; if (done_m1 !== 1'b1) begin tests_failed++;
            $display("FAIL rstmid_in_acc: got done=%b want 1", done_m1); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (busy_m1 !== 1'b0 || done_m1 !== 1'b0 || ovr_m1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_ctl: got busy=%b done=%b ovr=%b want 0 0 0",
                     busy_m1, done_m1, ovr_m1); end
        tests_run++; if (acc_m1 !== 32'd0 || aop_m1 !== ALU_MAC) begin tests_failed++;
            $display("FAIL rstmid_state: got acc=%0d op=%0d want 0 %0d",
                     acc_m1, aop_m1, ALU_MAC); end
        repeat (2) next_cycle();
        rst_n = 1'b1;
        req = 1'b1; op_in = ALU_XOR; rs1 = 32'hF0; rs2 = 32'h0F;
        @(negedge clk);
        tests_run++; if (aop_m1 !== ALU_XOR || ovr_m1 !== 1'b0 || busy_m1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_xor: got op=%0d ovr=%b busy=%b want %0d 0 0",
                     aop_m1, ovr_m1, busy_m1, ALU_XOR); end
        tests_run++; if (acc_m1 !== 32'd0 || acc_m3 !== 32'd0) begin tests_failed++;
            $display("FAIL rstmid_no_write: got m1=%0d m3=%0d want 0 0", acc_m1, acc_m3); end
        next_cycle();
        req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_latency();
        test_multi_acc();
        test_saturation();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
